// File: rtl/iic_reg_seq_if.sv
// Sequencer-to-IIC-master and sequencer-to-table-ROM signal bundle.
// The master modport is the sequencer side; the slave modport is the IIC master plus ROM.
interface iic_reg_seq_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int IDX_W  = 6
);
    logic [7:0]               device_id;
    logic                     iic_trig;
    logic                     w_r;
    logic [ADDR_W-1:0]        addr;
    logic [DATA_W-1:0]        data_in;
    logic                     busy;
    logic [DATA_W-1:0]        data_out;
    logic [IDX_W-1:0]         tbl_idx;
    logic [2+ADDR_W+DATA_W-1:0] tbl_entry;

    modport master (
        output device_id, iic_trig, w_r, addr, data_in, tbl_idx,
        input  busy, data_out, tbl_entry
    );
    modport slave (
        input  device_id, iic_trig, w_r, addr, data_in, tbl_idx,
        output busy, data_out, tbl_entry
    );
endinterface

// File: rtl/iic_reg_seq.sv
// Table-driven IIC init sequencer: probe, write/verify/delay/end opcodes, bounded
// retry with per-transaction timeout, restart on start, optional status polling in DONE.
module iic_reg_seq #(
    parameter int                ADDR_W      = 16,
    parameter int                DATA_W      = 8,
    parameter int                IDX_W       = 6,
    parameter logic [7:0]        DEV_ID      = 8'hB2,
    parameter logic [ADDR_W-1:0] PROBE_ADDR  = ADDR_W'(16'h0003),
    parameter logic [DATA_W-1:0] PROBE_DATA  = DATA_W'(8'h5A),
    parameter int                DELAY_UNIT  = 1000,
    parameter int                MAX_RETRY   = 3,
    parameter int                TIMEOUT     = 65535,
    parameter bit                POLL_EN     = 1'b1,
    parameter logic [ADDR_W-1:0] POLL_ADDR   = ADDR_W'(16'h0502),
    parameter int                POLL_PERIOD = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    iic_reg_seq_if.master     bus,
    output logic              init_over,
    output logic              init_err,
    output logic [IDX_W-1:0]  err_idx,
    output logic [DATA_W-1:0] poll_data,
    output logic              poll_valid
);
    localparam int DLY_MAX = ((2 ** DATA_W) - 1) * DELAY_UNIT;
    localparam int M1      = (TIMEOUT > POLL_PERIOD) ? TIMEOUT : POLL_PERIOD;
    localparam int CNT_MAX = (M1 > DLY_MAX) ? M1 : DLY_MAX;
    localparam int CNT_W   = $clog2(CNT_MAX + 2);
    localparam int RET_W   = $clog2(MAX_RETRY + 1);
    localparam logic [CNT_W-1:0] TMO       = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] POLL_LAST = CNT_W'(POLL_PERIOD - 1);

    typedef enum logic [3:0] {
        S_PROBE_W, S_PROBE_R, S_FETCH, S_DECODE, S_WAITB,
        S_DELAY, S_NEXT, S_FAIL, S_DONE, S_ERR
    } state_e;

    // What the outstanding transaction was for, so WAITB knows where to go next
    typedef enum logic [2:0] {K_PW, K_PR, K_WR, K_VF, K_POLL} kind_e;

    state_e              state_q, state_d;
    kind_e               kind_q, kind_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [RET_W-1:0]    retry_q, retry_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                trig_q, trig_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                over_q, over_d;
    logic                err_q, err_d;
    logic [IDX_W-1:0]    err_idx_q, err_idx_d;
    logic [DATA_W-1:0]   pdata_q, pdata_d;
    logic                pvalid_q, pvalid_d;
    logic                pend_q, pend_d;
    logic                busy_d_q;

    logic [1:0]          e_op;
    logic [ADDR_W-1:0]   e_addr;
    logic [DATA_W-1:0]   e_data;
    logic                busy_fall;
    logic [RET_W-1:0]    ret_inc;

    assign e_op      = bus.tbl_entry[ADDR_W+DATA_W +: 2];
    assign e_addr    = bus.tbl_entry[DATA_W +: ADDR_W];
    assign e_data    = bus.tbl_entry[DATA_W-1:0];
    assign busy_fall = busy_d_q & ~bus.busy;
    assign ret_inc   = retry_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_PROBE_W;
            kind_q    <= K_PW;
            cnt_q     <= '0;
            retry_q   <= '0;
            idx_q     <= '0;
            trig_q    <= 1'b0;
            wr_q      <= 1'b1;
            addr_q    <= '0;
            data_q    <= '0;
            over_q    <= 1'b0;
            err_q     <= 1'b0;
            err_idx_q <= '0;
            pdata_q   <= '0;
            pvalid_q  <= 1'b0;
            pend_q    <= 1'b0;
            busy_d_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            idx_q     <= idx_d;
            trig_q    <= trig_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            over_q    <= over_d;
            err_q     <= err_d;
            err_idx_q <= err_idx_d;
            pdata_q   <= pdata_d;
            pvalid_q  <= pvalid_d;
            pend_q    <= pend_d;
            busy_d_q  <= bus.busy;
        end
    end

    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        cnt_d     = cnt_q;
        retry_d   = retry_q;
        idx_d     = idx_q;
        trig_d    = 1'b0;
        wr_d      = wr_q;
        addr_d    = addr_q;
        data_d    = data_q;
        over_d    = over_q;
        err_d     = err_q;
        err_idx_d = err_idx_q;
        pdata_d   = pdata_q;
        pvalid_d  = 1'b0;
        pend_d    = pend_q;
        case (state_q)
            S_PROBE_W, S_PROBE_R: begin
                trig_d  = 1'b1;
                wr_d    = (state_q == S_PROBE_W);
                addr_d  = PROBE_ADDR;
                data_d  = PROBE_DATA;
                kind_d  = (state_q == S_PROBE_W) ? K_PW : K_PR;
                cnt_d   = '0;
                state_d = S_WAITB;
            end
            S_FETCH: begin
                if (cnt_q == CNT_W'(1)) state_d = S_DECODE;
                else                    cnt_d   = cnt_q + 1'b1;
            end
            S_DECODE: begin
                cnt_d = '0;
                case (e_op)
                    2'b00, 2'b01: begin
                        // On a verify read data_in carries the expected value; the master ignores it
                        trig_d  = 1'b1;
                        wr_d    = (e_op == 2'b00);
                        addr_d  = e_addr;
                        data_d  = e_data;
                        kind_d  = (e_op == 2'b00) ? K_WR : K_VF;
                        state_d = S_WAITB;
                    end
                    2'b10: begin
                        cnt_d   = CNT_W'(32'(e_data) * 32'(DELAY_UNIT));
                        state_d = S_DELAY;
                    end
                    default: begin
                        over_d  = 1'b1;
                        state_d = S_DONE;
                    end
                endcase
            end
            S_WAITB: begin
                if (kind_q == K_POLL && start) pend_d = 1'b1;
                // A completion in the expiry cycle still counts as a completion
                if (busy_fall) begin
                    cnt_d = '0;
                    case (kind_q)
                        K_PW: state_d = S_PROBE_R;
                        K_PR: begin
                            if (bus.data_out == PROBE_DATA) begin
                                idx_d   = '0;
                                state_d = S_FETCH;
                            end else begin
                                state_d = S_FAIL;
                            end
                        end
                        K_WR: state_d = S_NEXT;
                        K_VF: state_d = (bus.data_out == data_q) ? S_NEXT : S_FAIL;
                        default: begin
                            pdata_d  = bus.data_out;
                            pvalid_d = 1'b1;
                            state_d  = S_DONE;
                        end
                    endcase
                end else if (cnt_q == TMO) begin
                    cnt_d   = '0;
                    state_d = (kind_q == K_POLL) ? S_DONE : S_FAIL;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DELAY: begin
                if (cnt_q == '0) state_d = S_NEXT;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_NEXT: begin
                cnt_d = '0;
                if (&idx_q) begin
                    over_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_FAIL: begin
                // idx_q is held at 0 throughout the probe, so probe failures report 0
                err_idx_d = idx_q;
                retry_d   = ret_inc;
                idx_d     = '0;
                if (ret_inc < RET_W'(MAX_RETRY)) begin
                    state_d = S_PROBE_W;
                end else begin
                    err_d   = 1'b1;
                    state_d = S_ERR;
                end
            end
            S_DONE: begin
                if (start || pend_q) begin
                    over_d  = 1'b0;
                    err_d   = 1'b0;
                    retry_d = '0;
                    idx_d   = '0;
                    pend_d  = 1'b0;
                    state_d = S_PROBE_W;
                end else if (POLL_EN) begin
                    if (cnt_q == POLL_LAST) begin
                        trig_d  = 1'b1;
                        wr_d    = 1'b0;
                        addr_d  = POLL_ADDR;
                        kind_d  = K_POLL;
                        cnt_d   = '0;
                        state_d = S_WAITB;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_ERR: begin
                if (start) begin
                    over_d  = 1'b0;
                    err_d   = 1'b0;
                    retry_d = '0;
                    idx_d   = '0;
                    state_d = S_PROBE_W;
                end
            end
            default: state_d = S_PROBE_W;
        endcase
    end

    always_comb begin
        bus.device_id = DEV_ID;
        bus.iic_trig  = trig_q;
        bus.w_r       = wr_q;
        bus.addr      = addr_q;
        bus.data_in   = data_q;
        bus.tbl_idx   = idx_q;
        init_over     = over_q;
        init_err      = err_q;
        err_idx       = err_idx_q;
        poll_data     = pdata_q;
        poll_valid    = pvalid_q;
    end
endmodule

// File: tb/tb_iic_reg_seq.sv
// Directed bench for iic_reg_seq: behavioural IIC master + table ROM, hand-computed expectations.
module tb_iic_reg_seq;
    localparam int AW = 16, DW = 8, IW = 6, EW = 2 + AW + DW;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic init_over, init_err, poll_valid;
    logic [IW-1:0] err_idx;
    logic [DW-1:0] poll_data;

    iic_reg_seq_if #(.ADDR_W(AW), .DATA_W(DW), .IDX_W(IW)) bus ();

    iic_reg_seq #(
        .ADDR_W(AW), .DATA_W(DW), .IDX_W(IW), .DEV_ID(8'hB2),
        .PROBE_ADDR(16'h0003), .PROBE_DATA(8'h5A), .DELAY_UNIT(10),
        .MAX_RETRY(3), .TIMEOUT(100), .POLL_EN(1'b1),
        .POLL_ADDR(16'h0502), .POLL_PERIOD(200)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .bus(bus.master),
        .init_over(init_over), .init_err(init_err), .err_idx(err_idx),
        .poll_data(poll_data), .poll_valid(poll_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Table ROM, one cycle of latency after tbl_idx moves
    logic [EW-1:0] rom [0:63];
    always @(negedge clk) bus.tbl_entry = rom[bus.tbl_idx];

    // Behavioural IIC master: busy for 3 cycles after each trig, log every transaction
    int n_tr = 0, bcnt = 0, wide_trig = 0, pv_cnt = 0, pv_wide = 0, vf_bad_left = 0;
    int tr_cyc [64], fall_cyc [64];
    logic [AW-1:0] tr_addr [64];
    logic          tr_wr   [64];
    logic [DW-1:0] tr_dat  [64];
    logic [DW-1:0] resp = '0;
    logic [AW-1:0] hang_a = '0;
    bit   probe_ok = 1'b1, hang_en = 1'b0, hang_now = 1'b0, trig_prev = 1'b0, pv_prev = 1'b0;

    initial begin
        bus.busy = 1'b0;
        bus.data_out = '0;
    end

    always @(negedge clk) begin
        if (rst) begin
            bus.busy = 1'b0;
            bcnt = 0;
            hang_now = 1'b0;
        end else begin
            if (bcnt > 0 && !hang_now) begin
                bcnt--;
                if (bcnt == 0) begin
                    bus.busy = 1'b0;
                    bus.data_out = resp;
                    if (n_tr > 0 && n_tr <= 64) fall_cyc[n_tr-1] = cyc;
                end
            end
            if (bus.iic_trig) begin
                if (trig_prev) wide_trig++;
                if (n_tr < 64) begin
                    tr_cyc[n_tr] = cyc;
                    tr_addr[n_tr] = bus.addr;
                    tr_wr[n_tr] = bus.w_r;
                    tr_dat[n_tr] = bus.data_in;
                end
                if (bus.addr == 16'h0003) resp = probe_ok ? 8'h5A : 8'h00;
                else if (bus.addr == 16'h0900) begin
                    resp = (vf_bad_left > 0) ? 8'h21 : 8'h20;
                    if (vf_bad_left > 0 && !bus.w_r) vf_bad_left--;
                end
                else if (bus.addr == 16'h0502) resp = 8'h3C;
                else resp = 8'hEE;
                hang_now = hang_en && bus.w_r && (bus.addr == hang_a);
                bus.busy = 1'b1;
                bcnt = 3;
                n_tr++;
            end
        end
        trig_prev = bus.iic_trig;
        if (poll_valid) begin
            pv_cnt++;
            if (pv_prev) pv_wide++;
        end
        pv_prev = poll_valid;
    end

    int n_tests = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_tr(input string tag, input int k, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
        chk(tag, {tr_wr[k], tr_addr[k], (wr ? tr_dat[k] : 8'h00)}, {wr, a, (wr ? d : 8'h00)});
    endtask

    // sel 0: init_over, 1: init_err, 2: transaction count reaches arg
    task automatic wait_for(input int sel, input int arg, input int budget, input string tag);
        bit hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk);
            case (sel)
                0: hit = init_over;
                1: hit = init_err;
                default: hit = (n_tr >= arg);
            endcase
        end
        if (!hit) chk({tag, "_timeout"}, 0, 1);
    endtask

    task automatic set_tbl(input int i, input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
        rom[i] = {op, a, d};
    endtask

    int base, gap, p0, pvb;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        base = n_tr;
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = {2'b11, 16'h0, 8'h0};

        // T1: normal run
        set_tbl(0, 2'b00, 16'h1281, 8'h04);
        set_tbl(1, 2'b00, 16'h0016, 8'h04);
        set_tbl(2, 2'b11, 16'h0000, 8'h00);
        repeat (3) @(negedge clk);
        chk("rst_trig", bus.iic_trig, 0);
        chk("rst_wr", bus.w_r, 1);
        chk("rst_addr_data_idx", {bus.addr, bus.data_in, bus.tbl_idx}, 0);
        chk("rst_flags", {init_over, init_err, err_idx, poll_data, poll_valid}, 0);
        chk("dev_id", bus.device_id, 8'hB2);
        base = n_tr;
        rst = 1'b0;
        wait_for(0, 0, 2000, "t1_over");
        chk("t1_ntr", n_tr - base, 4);
        chk_tr("t1_tr0", base,     1'b1, 16'h0003, 8'h5A);
        chk_tr("t1_tr1", base + 1, 1'b0, 16'h0003, 8'h00);
        chk_tr("t1_tr2", base + 2, 1'b1, 16'h1281, 8'h04);
        chk_tr("t1_tr3", base + 3, 1'b1, 16'h0016, 8'h04);
        chk("t1_flags", {init_over, init_err}, 2'b10);
        chk("t1_trig_width", wide_trig, 0);

        // T2: probe readback wrong on every attempt
        probe_ok = 1'b0;
        do_reset();
        wait_for(1, 0, 3000, "t2_err");
        chk("t2_ntr", n_tr - base, 6);
        for (int k = 0; k < 6; k++) chk_tr("t2_tr", base + k, (k % 2 == 0), 16'h0003, 8'h5A);
        chk("t2_flags", {init_err, init_over, err_idx}, {2'b10, 6'd0});
        repeat (300) @(negedge clk);
        chk("t2_quiet", n_tr - base, 6);
        probe_ok = 1'b1;

        // T3: DELAY of 5 units of 10 cycles
        set_tbl(0, 2'b00, 16'h0010, 8'h11);
        set_tbl(1, 2'b10, 16'h0000, 8'h05);
        set_tbl(2, 2'b00, 16'h0012, 8'h33);
        set_tbl(3, 2'b11, 16'h0000, 8'h00);
        do_reset();
        wait_for(0, 0, 3000, "t3_over");
        chk("t3_ntr", n_tr - base, 4);
        chk_tr("t3_tr2", base + 2, 1'b1, 16'h0010, 8'h11);
        chk_tr("t3_tr3", base + 3, 1'b1, 16'h0012, 8'h33);
        gap = tr_cyc[base+3] - fall_cyc[base+2];
        chk("t3_gap_min", gap >= 50, 1);
        chk("t3_gap_max", gap <= 70, 1);

        // T4: verify mismatch once, then clean retry
        set_tbl(0, 2'b00, 16'h0020, 8'h01);
        set_tbl(1, 2'b01, 16'h0900, 8'h20);
        set_tbl(2, 2'b11, 16'h0000, 8'h00);
        vf_bad_left = 1;
        do_reset();
        wait_for(0, 0, 4000, "t4_over");
        chk("t4_ntr", n_tr - base, 8);
        chk_tr("t4_vf", base + 3, 1'b0, 16'h0900, 8'h00);
        chk_tr("t4_restart", base + 4, 1'b1, 16'h0003, 8'h5A);
        chk("t4_err_idx", err_idx, 1);
        chk("t4_flags", {init_over, init_err}, 2'b10);

        // T5: busy stuck high on the second table write
        set_tbl(0, 2'b00, 16'h0030, 8'hAA);
        set_tbl(1, 2'b00, 16'h0031, 8'hBB);
        set_tbl(2, 2'b11, 16'h0000, 8'h00);
        hang_en = 1'b1;
        hang_a = 16'h0031;
        do_reset();
        wait_for(1, 0, 5000, "t5_err");
        chk("t5_ntr", n_tr - base, 12);
        chk("t5_err_idx", err_idx, 1);
        // timeout at 100 -> FAIL at +101 -> PROBE_W at +102 -> trig at +103
        chk("t5_tmo_gap", tr_cyc[base+4] - tr_cyc[base+3], 103);
        chk_tr("t5_retry", base + 4, 1'b1, 16'h0003, 8'h5A);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t5_err_clr", init_err, 0);
        wait_for(2, base + 13, 50, "t5_restart");
        chk_tr("t5_restart", base + 12, 1'b1, 16'h0003, 8'h5A);
        hang_en = 1'b0;

        // T6: status polling in DONE, then reset mid-poll
        set_tbl(0, 2'b00, 16'h0040, 8'h55);
        set_tbl(1, 2'b11, 16'h0000, 8'h00);
        do_reset();
        wait_for(0, 0, 2000, "t6_over");
        p0 = n_tr;
        pvb = pv_cnt;
        wait_for(2, p0 + 2, 1000, "t6_polls");
        repeat (6) @(negedge clk);
        chk_tr("t6_poll0", p0,     1'b0, 16'h0502, 8'h00);
        chk_tr("t6_poll1", p0 + 1, 1'b0, 16'h0502, 8'h00);
        gap = tr_cyc[p0+1] - tr_cyc[p0];
        chk("t6_gap_range", (gap >= 200) && (gap <= 210), 1);
        chk("t6_poll_data", poll_data, 8'h3C);
        chk("t6_pv_cnt", pv_cnt - pvb, 2);
        chk("t6_pv_width", pv_wide, 0);
        chk("t6_over", init_over, 1);
        wait_for(2, p0 + 3, 400, "t6_poll2");
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_rst_trig_wr", {bus.iic_trig, bus.w_r}, 2'b01);
        chk("t6_rst_addr_data_idx", {bus.addr, bus.data_in, bus.tbl_idx}, 0);
        chk("t6_rst_flags", {init_over, init_err, err_idx, poll_data, poll_valid}, 0);
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
